// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // One received character plus the line-error flags captured with it.
    typedef struct packed {
        logic                   perror;
        logic                   ferror;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    // Ceiling log2 used for elaboration-time parameter checking.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - 1-bit rising-edge detector
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : level input
//   rise  : high for the cycle in which d is 1 and was 0 on the previous edge
//
// The history register resets to 0, so a level that is already high when
// reset releases is reported as a rising edge on the first cycle.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through FIFO behind the UART receiver
//
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   Rx_DATA/VALID/FERROR/PERROR : receiver outputs; one push per VALID rising edge
//   rd_en                  : pop the head entry (ignored while empty)
//   clr_ovf                : clear sticky overflow (and err_cnt when present)
//   rd_data/ferror/perror  : head entry, read combinationally from storage
//   rd_valid, full, count  : occupancy status (registered)
//   overflow               : sticky, a push was lost because the FIFO was full
//   err_cnt                : only with UART_RX_FIFO_DROP_ERR_EN; saturating count
//                            of bytes discarded for frame/parity errors
//
// Build option: define UART_RX_FIFO_DROP_ERR_EN to discard errored bytes
// instead of storing them.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] Rx_DATA,
    input  logic                   Rx_VALID,
    input  logic                   Rx_FERROR,
    input  logic                   Rx_PERROR,
    input  logic                   rd_en,
    input  logic                   clr_ovf,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_ferror,
    output logic                   rd_perror,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   overflow,
    output logic [PTR_W:0]         count
`ifdef UART_RX_FIFO_DROP_ERR_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    if (PTR_W != clog2(DEPTH) || DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_fifo: DEPTH must be a power of two in 2..64 and PTR_W = log2(DEPTH)");
    end

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    rx_entry_t      mem [DEPTH];
    rx_entry_t      head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0] count_nxt;
    logic           push;
    logic           push_ok;
    logic           do_pop;
    logic           wr_fire;
    logic           ovf_set;

    rise_detect u_valid_rise (
        .clk   (clk),
        .rst_n (reset),
        .d     (Rx_VALID),
        .rise  (push)
    );

`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic drop_err;
    assign drop_err = push & (Rx_FERROR | Rx_PERROR);
    assign push_ok  = push & ~drop_err;
`else
    assign push_ok  = push;
`endif

    assign do_pop  = rd_en & rd_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_fire = push_ok & (~full | do_pop);
    assign ovf_set = push_ok & full & ~do_pop;

    assign count_nxt = count + {{PTR_W{1'b0}}, wr_fire} - {{PTR_W{1'b0}}, do_pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            full     <= (count_nxt == FULL_CNT);
            // Set has priority over clear so a loss is never hidden.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is intentionally left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= '{perror: Rx_PERROR, ferror: Rx_FERROR, data: Rx_DATA};
        end
    end

    assign head    = mem[rd_ptr];
    assign rd_data = head.data;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic unused_head_flags;
    assign unused_head_flags = head.perror ^ head.ferror;
    assign rd_ferror = 1'b0;
    assign rd_perror = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (clr_ovf) begin
            err_cnt <= '0;
        end else if (drop_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign rd_ferror = head.ferror;
    assign rd_perror = head.perror;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard testbench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic           clk;
    logic           reset;
    logic [7:0]     Rx_DATA;
    logic           Rx_VALID;
    logic           Rx_FERROR;
    logic           Rx_PERROR;
    logic           rd_en;
    logic           clr_ovf;
    logic [7:0]     rd_data;
    logic           rd_ferror;
    logic           rd_perror;
    logic           rd_valid;
    logic           full;
    logic           overflow;
    logic [PTR_W:0] count;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [7:0]     err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Expected entries {perror, ferror, data} in FIFO order.
    logic [9:0] model_q[$];

    uart_rx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Rx_DATA   (Rx_DATA),
        .Rx_VALID  (Rx_VALID),
        .Rx_FERROR (Rx_FERROR),
        .Rx_PERROR (Rx_PERROR),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .rd_data   (rd_data),
        .rd_ferror (rd_ferror),
        .rd_perror (rd_perror),
        .rd_valid  (rd_valid),
        .full      (full),
        .overflow  (overflow),
        .count     (count)
`ifdef UART_RX_FIFO_DROP_ERR_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One receiver strobe; the model only accepts the byte if there is room.
    task automatic push_byte(input logic [7:0] d, input logic fe, input logic pe);
        @(negedge clk);
        Rx_DATA   = d;
        Rx_FERROR = fe;
        Rx_PERROR = pe;
        Rx_VALID  = 1'b1;
        @(negedge clk);
        Rx_VALID  = 1'b0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
        if (fe || pe) return;
`endif
        if (model_q.size() < DEPTH) model_q.push_back({pe, fe, d});
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] exp;
        @(negedge clk);
        if (model_q.size() == 0) begin
            check({tag, "_model_empty"}, 32'd1, 32'd0);
        end else begin
            exp = model_q.pop_front();
            check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
            check({tag, "_entry"}, {22'd0, rd_perror, rd_ferror, rd_data}, {22'd0, exp});
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        Rx_DATA   = 8'h00;
        Rx_VALID  = 1'b0;
        Rx_FERROR = 1'b0;
        Rx_PERROR = 1'b0;
        rd_en     = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b1;

        // Long VALID level yields exactly one push.
        @(negedge clk);
        Rx_DATA  = 8'hA5;
        Rx_VALID = 1'b1;
        repeat (20) @(negedge clk);
        Rx_VALID = 1'b0;
        model_q.push_back({2'b00, 8'hA5});
        check("hold_count", {28'd0, count}, 32'd1);
        pop_check("hold");
        check("hold_empty", {28'd0, count}, 32'd0);

        // Pop while empty has no effect.
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("empty_pop_count", {28'd0, count}, 32'd0);
        check("empty_pop_valid", {31'd0, rd_valid}, 32'd0);

        // Two full fill/drain passes to exercise pointer wrap.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 1; i <= DEPTH; i++) begin
                push_byte(8'((pass << 4) + i), 1'b0, 1'b0);
                check("fill_full", {31'd0, full}, {31'd0, (i == DEPTH)});
            end
            check("fill_count", {28'd0, count}, DEPTH);
            for (int i = 0; i < DEPTH; i++) pop_check("drain");
            check("drain_count", {28'd0, count}, 32'd0);
        end

        // Overflow: dropped byte, sticky flag, set beats clear, then clear.
        for (int i = 0; i < DEPTH; i++) push_byte(8'h60 + 8'(i), 1'b0, 1'b0);
        push_byte(8'h99, 1'b0, 1'b0);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_count", {28'd0, count}, DEPTH);
        clr_ovf = 1'b1;
        push_byte(8'h99, 1'b0, 1'b0);
        clr_ovf = 1'b0;
        check("ovf_set_wins", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO: simultaneous push and pop.
        @(negedge clk);
        check("pp_head", {24'd0, rd_data}, {24'd0, model_q[0][7:0]});
        Rx_DATA  = 8'h55;
        Rx_VALID = 1'b1;
        rd_en    = 1'b1;
        @(negedge clk);
        Rx_VALID = 1'b0;
        rd_en    = 1'b0;
        void'(model_q.pop_front());
        model_q.push_back({2'b00, 8'h55});
        check("pp_count", {28'd0, count}, DEPTH);
        check("pp_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_check("pp_drain");
        check("pp_empty", {28'd0, count}, 32'd0);

        // Errored bytes.
        push_byte(8'h3C, 1'b0, 1'b1);
        push_byte(8'h7E, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        check("err_count", {28'd0, count}, 32'd0);
        check("err_cnt", {24'd0, err_cnt}, 32'd2);
`else
        check("err_count", {28'd0, count}, 32'd2);
        pop_check("err_perr");
        pop_check("err_ferr");
`endif

        // Asynchronous reset with entries stored.
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
        check("pre_rst_count", {28'd0, count}, 32'd5);
        @(negedge clk);
        #2;
        reset    = 1'b0;
        Rx_DATA  = 8'h42;
        Rx_VALID = 1'b1;
        #1;
        check("async_count", {28'd0, count}, 32'd0);
        check("async_valid", {31'd0, rd_valid}, 32'd0);
        check("async_ovf", {31'd0, overflow}, 32'd0);
        model_q.delete();

        // VALID still high at reset release gives one push.
        @(negedge clk);
        reset = 1'b1;
        model_q.push_back({2'b00, 8'h42});
        repeat (3) @(negedge clk);
        check("rel_count", {28'd0, count}, 32'd1);
        Rx_VALID = 1'b0;
        pop_check("rel");
        check("rel_empty", {28'd0, count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream consumer of the UART receiver.
- Captures each received byte and its frame/parity error flags into a small circular FIFO on the rising edge of the receiver's valid flag.
- Presents entries to the system side with a first-word-fall-through read interface.
- Decouples the bit-rate receiver from a slower consumer, such as the display/command logic, and reports overflow.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..64.
- PTR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; same clock as the receiver.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- Rx_DATA  input  8  received byte from the receiver.
- Rx_VALID  input  1  receiver valid level; may stay high for many cycles.
- Rx_FERROR  input  1  frame error for the current byte.
- Rx_PERROR  input  1  parity error for the current byte.
- rd_en  input  1  pop request for the head entry.
- clr_ovf  input  1  clears the sticky overflow flag.
- rd_data  output  8  head entry byte.
- rd_ferror  output  1  head entry frame-error flag.
- rd_perror  output  1  head entry parity-error flag.
- rd_valid  output  1  FIFO not empty; head entry is valid.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a push was lost.
- count  output  PTR_W+1  number of stored entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr, count, overflow and the edge-detect register valid_q are cleared.
  - rd_valid=0, full=0, overflow=0, count=0.
  - Storage RAM is not cleared; rd_data/rd_ferror/rd_perror are don't-care while rd_valid=0.
- Push event:
  - valid_q registers Rx_VALID each cycle.
  - push = Rx_VALID & ~valid_q, i.e. one push per byte regardless of how long Rx_VALID stays high.
  - On push, {Rx_PERROR, Rx_FERROR, Rx_DATA} is written at wr_ptr on that clock edge.
- Pop: pop = rd_en & rd_valid. rd_en while empty is ignored and has no side effects.
- Latency:
  - Push on the edge ending cycle n; count/rd_valid/full reflect it in cycle n+1.
  - On an empty FIFO, rd_data is valid in cycle n+1 (fall-through: outputs are driven directly from storage[rd_ptr]).
- Pointers: PTR_W bits, wrap naturally from DEPTH-1 to 0. count is tracked separately and is the only source of full/empty.
- Simultaneous push and pop:
  - Non-empty, non-full: both occur, count unchanged.
  - Full: both occur (the pop frees the slot), count stays DEPTH, overflow unchanged.
  - Empty: only the push occurs; the pop is ignored because rd_valid=0.
- Overflow:
  - Push while full without a pop: data is dropped, pointers unchanged, overflow set to 1.
  - overflow holds until clr_ovf=1 on a clock edge.
  - If clr_ovf and a new overflow coincide, set wins (overflow stays 1).
- Reset mid-frame: a Rx_VALID still high when reset deasserts produces one push on the first cycle after reset. This is required behaviour, because valid_q resets to 0.
- There is no state machine beyond the counters; all outputs except the RAM read are registered.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_ERR_EN.
- Defined:
  - A push whose Rx_FERROR or Rx_PERROR is 1 is discarded and not stored.
  - An 8-bit saturating output err_cnt counts discarded bytes; it resets to 0, saturates at 255, and is cleared by clr_ovf.
  - rd_ferror/rd_perror are tied to 0.
- Not defined:
  - All bytes are stored with their flags.
  - There is no err_cnt port.

Decomposition:
- Package uart_pkg: UART_DATA_W=8, typedef rx_entry_t {perror, ferror, data[7:0]}, function clog2 for PTR_W checking.
- One natural sub-module: rise_detect (1-bit registered rising-edge detector with async active-low reset), instantiated for Rx_VALID.
- Storage and pointer logic stay in uart_rx_fifo.

Test Plan:
- Reset, then hold Rx_VALID=1 for 20 cycles with Rx_DATA=0xA5 -> exactly one push: count=1, rd_valid=1, rd_data=0xA5, flags 0.
- Push 0x01..0x08 (DEPTH=8), then pop all -> full=1 after the 8th push; pops return 0x01..0x08 in order; count returns to 0; wr_ptr/rd_ptr wrap cleanly on a second fill.
- Fill to 8 entries, push 0x99 without a pop -> overflow=1, count=8, 0x99 never read. Pulse clr_ovf -> overflow=0.
- Full FIFO, push 0x55 and rd_en in the same cycle -> count stays 8, head advances, 0x55 is read last.
- Push 0x3C with Rx_PERROR=1 -> entry has rd_perror=1. With UART_RX_FIFO_DROP_ERR_EN: count stays 0 and err_cnt=1.
- Assert reset asynchronously mid-sequence with 5 entries stored -> count=0, rd_valid=0, overflow=0 immediately, with no clock edge required.
